// File: rtl/video_fetch_pkg.sv
// Shared constants, FSM state encodings and helpers for the video fetch scheduler.
package video_fetch_pkg;

  localparam int unsigned DEF_ADDR_W     = 30;
  localparam int unsigned DEF_LINE_WORDS = 160;
  localparam int unsigned DEF_LINES      = 480;
  localparam int unsigned DEF_FIFO_AW    = 9;
  localparam int unsigned DEF_BURST      = 8;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_WAIT_VS = 3'd1;
  localparam logic [2:0] ST_ARM     = 3'd2;
  localparam logic [2:0] ST_RUN     = 3'd3;
  localparam logic [2:0] ST_READ    = 3'd4;
  localparam logic [2:0] ST_DRAIN   = 3'd5;
  localparam logic [2:0] ST_DONE    = 3'd6;

  // Highest FIFO level at which a whole burst still fits.
  function automatic int unsigned room_thresh(input int unsigned fifo_aw,
                                              input int unsigned burst);
    return (32'd1 << fifo_aw) - burst;
  endfunction

endpackage

// File: rtl/video_fetch_addrgen.sv
// Frame position tracking: read address, line start, word/line counters.
// With VIDEO_FETCH_DBLY_EN defined, even output lines rewind to replay the source line.
module video_fetch_addrgen
  import video_fetch_pkg::*;
#(
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned LINE_WORDS = DEF_LINE_WORDS,
  parameter int unsigned LINES      = DEF_LINES
) (
  input  logic              clk_pixel,
  input  logic              resetn,
  input  logic              load,
  input  logic              advance,
  input  logic [ADDR_W-1:0] base_addr,
`ifdef VIDEO_FETCH_DBLY_EN
  input  logic              dbl_y,
`endif
  output logic [ADDR_W-1:0] rd_addr,
  output logic              frame_complete,
  output logic              last_word
);

  localparam int unsigned WC_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam int unsigned LC_W = $clog2(LINES + 1);

  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0] line_start_q, line_start_d;
  logic [WC_W-1:0]   word_cnt_q, word_cnt_d;
  logic [LC_W-1:0]   line_cnt_q, line_cnt_d;
  logic              line_end;
  logic              rewind;

`ifdef VIDEO_FETCH_DBLY_EN
  logic dbl_q, dbl_d;

  assign dbl_d  = load ? dbl_y : dbl_q;
  assign rewind = dbl_q & ~line_cnt_q[0];

  always_ff @(posedge clk_pixel or negedge resetn) begin
    if (!resetn) dbl_q <= 1'b0;
    else         dbl_q <= dbl_d;
  end
`else
  assign rewind = 1'b0;
`endif

  assign line_end       = (word_cnt_q == WC_W'(LINE_WORDS - 1));
  assign last_word      = line_end && (line_cnt_q == LC_W'(LINES - 1));
  assign frame_complete = (line_cnt_q == LC_W'(LINES));
  assign rd_addr        = rd_addr_q;

  // NOTE: every always_comb target gets a default first, otherwise the hold path infers a latch.
  always_comb begin
    rd_addr_d    = rd_addr_q;
    line_start_d = line_start_q;
    word_cnt_d   = word_cnt_q;
    line_cnt_d   = line_cnt_q;
    if (load) begin
      rd_addr_d    = base_addr;
      line_start_d = base_addr;
      word_cnt_d   = '0;
      line_cnt_d   = '0;
    end else if (advance) begin
      if (line_end) begin
        word_cnt_d = '0;
        line_cnt_d = line_cnt_q + LC_W'(1);
        if (rewind) begin
          rd_addr_d = line_start_q;
        end else begin
          rd_addr_d    = rd_addr_q + ADDR_W'(1);
          line_start_d = rd_addr_q + ADDR_W'(1);
        end
      end else begin
        word_cnt_d = word_cnt_q + WC_W'(1);
        rd_addr_d  = rd_addr_q + ADDR_W'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_pixel or negedge resetn) begin
    if (!resetn) begin
      rd_addr_q    <= '0;
      line_start_q <= '0;
      word_cnt_q   <= '0;
      line_cnt_q   <= '0;
    end else begin
      rd_addr_q    <= rd_addr_d;
      line_start_q <= line_start_d;
      word_cnt_q   <= word_cnt_d;
      line_cnt_q   <= line_cnt_d;
    end
  end

endmodule

// File: rtl/video_fetch_ctrl.sv
// Framebuffer prefetch scheduler: vsync-restarted, FIFO-throttled single-word reads.
// Optional line doubling (dbl_y input) is built when VIDEO_FETCH_DBLY_EN is defined.
module video_fetch_ctrl
  import video_fetch_pkg::*;
#(
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned LINE_WORDS = DEF_LINE_WORDS,
  parameter int unsigned LINES      = DEF_LINES,
  parameter int unsigned FIFO_AW    = DEF_FIFO_AW,
  parameter int unsigned BURST      = DEF_BURST
) (
  input  logic               clk_pixel,
  input  logic               resetn,
  input  logic               enable,
  input  logic [ADDR_W-1:0]  base_addr,
`ifdef VIDEO_FETCH_DBLY_EN
  input  logic               dbl_y,
`endif
  input  logic               vga_vsync,
  input  logic               fetch_next,
  input  logic [FIFO_AW:0]   fifo_level,
  input  logic               fifo_empty,
  output logic               rd_strobe,
  output logic [ADDR_W-1:0]  rd_addr,
  input  logic               rd_ack,
  input  logic [31:0]        rd_data,
  output logic               fifo_wr,
  output logic [31:0]        fifo_wdata,
  output logic               fifo_rst,
  output logic               frame_done,
  output logic               underrun
);

  localparam int unsigned    BC_W     = $clog2(BURST + 1);
  localparam logic [FIFO_AW:0] ROOM_LVL = (FIFO_AW + 1)'(room_thresh(FIFO_AW, BURST));

  logic [2:0]      state_q, state_d;
  logic            vsync_q;
  logic            rd_strobe_q, rd_strobe_d;
  logic [BC_W-1:0] burst_cnt_q, burst_cnt_d;
  logic            frame_done_q, frame_done_d;
  logic            underrun_q, underrun_d;
  logic            drain_arm_q, drain_arm_d;
  logic            vs_rise, ack_hit, room_ok;
  logic            load, advance, wr_c;
  logic            frame_complete, last_word;

  video_fetch_addrgen #(
    .ADDR_W     (ADDR_W),
    .LINE_WORDS (LINE_WORDS),
    .LINES      (LINES)
  ) u_addrgen (
    .clk_pixel      (clk_pixel),
    .resetn         (resetn),
    .load           (load),
    .advance        (advance),
    .base_addr      (base_addr),
`ifdef VIDEO_FETCH_DBLY_EN
    .dbl_y          (dbl_y),
`endif
    .rd_addr        (rd_addr),
    .frame_complete (frame_complete),
    .last_word      (last_word)
  );

  assign vs_rise = vga_vsync & ~vsync_q;
  assign ack_hit = rd_strobe_q & rd_ack;
  assign room_ok = (fifo_level <= ROOM_LVL);

  always_comb begin
    state_d      = state_q;
    rd_strobe_d  = rd_strobe_q;
    burst_cnt_d  = burst_cnt_q;
    frame_done_d = frame_done_q;
    drain_arm_d  = drain_arm_q;
    load         = 1'b0;
    advance      = 1'b0;
    wr_c         = 1'b0;
    case (state_q)
      ST_IDLE:    if (enable) state_d = ST_WAIT_VS;
      ST_WAIT_VS: begin
        if (!enable)      state_d = ST_IDLE;
        else if (vs_rise) state_d = ST_ARM;
      end
      ST_ARM: begin
        load         = 1'b1;
        burst_cnt_d  = '0;
        frame_done_d = 1'b0;
        rd_strobe_d  = 1'b0;
        state_d      = enable ? ST_RUN : ST_IDLE;
      end
      ST_RUN: begin
        if (!enable)             state_d = ST_IDLE;
        else if (vs_rise)        state_d = ST_ARM;
        else if (frame_complete) begin
          frame_done_d = 1'b1;
          state_d      = ST_DONE;
        end else if (room_ok) begin
          burst_cnt_d = '0;
          rd_strobe_d = 1'b1;
          state_d     = ST_READ;
        end
      end
      ST_READ: begin
        if (ack_hit) begin
          // Accepted word goes straight into the FIFO, even if an abort lands this cycle.
          wr_c        = 1'b1;
          advance     = 1'b1;
          rd_strobe_d = 1'b0;
          burst_cnt_d = burst_cnt_q + BC_W'(1);
          if (last_word) frame_done_d = 1'b1;
          if (!enable)      state_d = ST_IDLE;
          else if (vs_rise) state_d = ST_ARM;
          else if ((burst_cnt_q + BC_W'(1) == BC_W'(BURST)) || last_word) state_d = ST_RUN;
        end else if (rd_strobe_q) begin
          if (!enable || vs_rise) begin
            drain_arm_d = enable & vs_rise;
            state_d     = ST_DRAIN;
          end
        end else begin
          if (!enable)      state_d = ST_IDLE;
          else if (vs_rise) state_d = ST_ARM;
          else              rd_strobe_d = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (vs_rise) drain_arm_d = 1'b1;
        if (rd_ack) begin
          rd_strobe_d = 1'b0;
          drain_arm_d = 1'b0;
          state_d     = (enable && (drain_arm_q || vs_rise)) ? ST_ARM : ST_IDLE;
        end
      end
      ST_DONE: begin
        if (!enable)      state_d = ST_IDLE;
        else if (vs_rise) state_d = ST_ARM;
      end
      default: begin
        rd_strobe_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // Set wins over the ARM clear so a same-cycle underrun is never lost.
  assign underrun_d = (fetch_next & fifo_empty) ? 1'b1 :
                      (state_q == ST_ARM)       ? 1'b0 : underrun_q;

  always_ff @(posedge clk_pixel or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      vsync_q      <= 1'b0;
      rd_strobe_q  <= 1'b0;
      burst_cnt_q  <= '0;
      frame_done_q <= 1'b0;
      underrun_q   <= 1'b0;
      drain_arm_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      vsync_q      <= vga_vsync;
      rd_strobe_q  <= rd_strobe_d;
      burst_cnt_q  <= burst_cnt_d;
      frame_done_q <= frame_done_d;
      underrun_q   <= underrun_d;
      drain_arm_q  <= drain_arm_d;
    end
  end

  assign rd_strobe  = rd_strobe_q;
  assign fifo_wr    = wr_c;
  assign fifo_wdata = rd_data;
  assign fifo_rst   = (state_q == ST_ARM);
  assign frame_done = frame_done_q;
  assign underrun   = underrun_q;

endmodule
